// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single-ported data memory
module dmem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_DEPTH_LOG2 = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        r_state;
    logic              r_last_grant;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic w_idle;
    logic w_access;
    logic w_resp;
    logic w_in_range;
    logic w_gnt0;
    logic w_gnt1;

    // No grant while reset is asserted, even in IDLE.
    assign w_idle   = (r_state == S_IDLE) && !rst;
    assign w_access = (r_state == S_ACCESS);
    assign w_resp   = (r_state == S_RESP);

    assign w_in_range = ((r_addr >> MEM_DEPTH_LOG2) == '0);

    // On a tie the port that did not win last time takes the grant.
    assign w_gnt0 = w_idle && m0_req && (!m1_req || r_last_grant);
    assign w_gnt1 = w_idle && m1_req && (!m0_req || !r_last_grant);

    assign m0_gnt = w_gnt0;
    assign m1_gnt = w_gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_state      <= S_ACCESS;
                        r_owner      <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_we         <= w_gnt1 ? m1_we    : m0_we;
                        r_addr       <= w_gnt1 ? m1_addr  : m0_addr;
                        r_wdata      <= w_gnt1 ? m1_wdata : m0_wdata;
                    end
                end
                S_ACCESS: begin
                    r_rdata <= (!r_we && w_in_range) ? mem_rd : '0;
                    r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_we = w_access && r_we && w_in_range && !rst;
    assign mem_a  = r_addr;
    assign mem_wd = r_wdata;

    assign m0_rvalid = w_resp && !r_owner;
    assign m1_rvalid = w_resp && r_owner;
    assign m0_rdata  = m0_rvalid ? r_rdata : '0;
    assign m1_rdata  = m1_rvalid ? r_rdata : '0;
    assign m0_err    = m0_rvalid && !w_in_range;
    assign m1_err    = m1_rvalid && !w_in_range;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of requester and memory address (word index).
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MEM_DEPTH_LOG2, default 16, log2 of data memory words (64k).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mN_req  input  1  (N=0,1) access request; held with fields stable until mN_gnt.
REQ-007 mN_we  input  1  1 = write, 0 = read.
REQ-008 mN_addr  input  ADDR_W  word address.
REQ-009 mN_wdata  input  DATA_W  write data.
REQ-010 mN_gnt  output  1  request accepted this cycle (combinational).
REQ-011 mN_rvalid  output  1  one-cycle completion pulse, reads and writes.
REQ-012 mN_rdata  output  DATA_W  read data, valid with mN_rvalid.
REQ-013 mN_err  output  1  out-of-range flag, valid with mN_rvalid.
REQ-014 mem_we  output  1  to data memory write enable.
REQ-015 mem_a  output  ADDR_W  to data memory address.
REQ-016 mem_wd  output  DATA_W  to data memory write data.
REQ-017 mem_rd  input  DATA_W  asynchronous read data from data memory.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accept; ACCESS->RESP always; RESP->IDLE always.
REQ-019 Accept only in IDLE; at most one mN_gnt high per cycle; gnt never high in ACCESS/RESP.
REQ-020 Single requester asserting in IDLE is granted that cycle.
REQ-021 Both asserting: round-robin; requester not granted last wins; last_grant updates on each accept.
REQ-022 On accept, latch owner, we, addr, wdata into command registers.
REQ-023 ACCESS: mem_a/mem_wd driven from latched command; mem_we = latched we AND in-range AND NOT rst.
REQ-024 In-range: addr[ADDR_W-1:MEM_DEPTH_LOG2] == 0; out-of-range write SHALL NOT assert mem_we.
REQ-025 ACCESS: capture mem_rd into rdata register for in-range reads; capture 0 for writes or out-of-range.
REQ-026 RESP: owner's rvalid = 1 for exactly one cycle, rdata = captured value, err = out-of-range flag; non-owner outputs 0.
REQ-027 Latency: accept cycle N, memory access N+1, rvalid N+2; new accept earliest N+3; one access per 3 cycles max.
REQ-028 mem_we = 0 outside ACCESS; mem_a/mem_wd hold latched command in all states.
REQ-029 Request dropped before gnt: no access, no state change.
REQ-030 rvalid/rdata/err of a port SHALL be 0 whenever that port's rvalid is 0.

Reset
REQ-031 On rst: state = IDLE, last_grant = 1 (m0 wins first tie), command and rdata registers = 0, all outputs 0.
REQ-032 rst during ACCESS: mem_we forced 0 that cycle; transaction discarded, no rvalid issued.
REQ-033 rst during RESP: rvalid suppressed from next cycle; no gnt issued in the reset cycle.

Verification
REQ-034 Post-reset m0 write addr 0x2000 data 10, then m0 read 0x2000 -> gnt cycle N, mem_we=1 cycle N+1, later read rvalid with rdata=10, err=0.
REQ-035 m0 and m1 reads held continuously -> grants alternate m0,m1,m0,m1 every 3 cycles; no double grant.
REQ-036 m1 write addr 0x0001_0000 -> mem_we never asserted, m1_rvalid=1 with m1_err=1, rdata=0.
REQ-037 rst asserted in ACCESS of m0 write 0x10 data 0xDEAD -> mem_we=0, no rvalid; later read 0x10 returns prior value.
REQ-038 m1 request while m0 transaction in ACCESS -> m1_gnt=0 until IDLE, then granted; m0 rvalid precedes m1_gnt.
REQ-039 Request withdrawn before grant (m1 req while busy, dropped in RESP) -> no m1 gnt, no memory activity.
